// File: rtl/mem_pkg.sv
// Shared types and default widths for the data memory controller.
package mem_pkg;

  typedef enum logic {
    CLEAR,
    IDLE
  } mem_state_t;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 8;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered, enable-gated read port.
module mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only moves on an accepted read, so it doubles as the response hold buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: valid/ready requests, one-deep read response, zero-fill after reset.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  mem_state_t        state;
  logic [ADDR_W-1:0] clear_cnt;
  logic              req_fire;
  logic              rd_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign busy      = (state == CLEAR);
  assign req_ready = (state == IDLE) && (!rsp_valid || rsp_ready);
  assign req_fire  = req_valid && req_ready;
  assign rd_fire   = req_fire && !req_write;

  // The clear sequence owns the RAM port while busy; requests are blocked then anyway.
  always_comb begin
    mem_we    = req_fire && req_write;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clear_cnt;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clear_cnt <= '0;
      rsp_valid <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          clear_cnt <= clear_cnt + 1'b1;
          if (clear_cnt == LastAddr) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (rd_fire) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst  (reset),
    .we   (mem_we),
    .re   (rd_fire),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(rsp_rdata)
  );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl with a 16-word, 8-bit memory.
module tb_data_memory_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       busy;

  int checks = 0;
  int errors = 0;

  data_memory_ctrl #(
    .DATA_W        (8),
    .ADDR_W        (4),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles until busy drops, bounded so a stuck clear cannot hang the run.
  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, n, 16);
    chk({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic pulse_reset;
    reset     = 1'b1;
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_rdata, exp);
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    // Reset and clear
    pulse_reset();
    chk("rst_busy", busy, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    wait_clear("clear_len");
    for (int i = 0; i < 16; i++) rd("clear_rd", 4'(i), 8'h00);

    // Write then read on the next edge
    wr(4'd3, 8'hA5);
    chk("wr_no_rsp", rsp_valid, 0);
    rd("wr_rd", 4'd3, 8'hA5);

    // Backpressure: a blocked write must be ignored
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd3;
    tick();
    req_write = 1'b1;
    req_wdata = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_rdata, 8'hA5);
      chk("bp_req_ready", req_ready, 0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 1);
    tick();
    chk("bp_drained", rsp_valid, 0);
    rd("bp_ignored_wr", 4'd3, 8'hA5);

    // Streaming writes then back-to-back reads
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 4'(i);
      req_wdata = 8'(8'h10 + i);
      tick();
    end
    req_write = 1'b0;
    req_addr  = 4'd0;
    tick();
    for (int i = 1; i <= 16; i++) begin
      chk("stream_valid", rsp_valid, 1);
      chk("stream_data", rsp_rdata, 32'(8'h10 + i - 1));
      if (i < 16) begin
        chk("stream_ready", req_ready, 1);
        req_addr = 4'(i);
      end else begin
        req_valid = 1'b0;
      end
      tick();
    end
    chk("stream_done", rsp_valid, 0);

    // Reset mid-clear restarts the fill
    pulse_reset();
    for (int i = 0; i < 7; i++) tick();
    chk("midclr_busy", busy, 1);
    pulse_reset();
    wait_clear("midclr_len");
    for (int i = 0; i < 16; i++) rd("midclr_rd", 4'(i), 8'h00);

    // Reset with a pending response
    tick();
    wr(4'd9, 8'h5A);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd9;
    tick();
    req_valid = 1'b0;
    chk("pend_valid", rsp_valid, 1);
    chk("pend_data", rsp_rdata, 8'h5A);
    pulse_reset();
    chk("pend_rst_valid", rsp_valid, 0);
    chk("pend_rst_data", rsp_rdata, 0);
    chk("pend_rst_busy", busy, 1);
    rsp_ready = 1'b1;
    wait_clear("pend_clear_len");
    rd("pend_rd9", 4'd9, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
